// File: rtl/cnt60_bcd_timer.sv
// Two-stage BCD minutes:seconds counter (00:00-59:59) with run/stop FSM,
// synchronous clear, validated BCD preset load and a one-cycle wrap carry.
module cnt60_bcd_timer #(
  parameter bit MIN_EN       = 1'b1,
  parameter bit RUN_AT_RESET = 1'b0
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       ENABLE,
  input  logic       START_STOP,
  input  logic       CLEAR,
  input  logic       LOAD,
  input  logic [7:0] LOAD_MIN,
  input  logic [7:0] LOAD_SEC,
  output logic [7:0] SEC,
  output logic [7:0] MIN,
  output logic       RUNNING,
  output logic       CARRY,
  output logic       LOAD_ERR
);

  typedef enum logic [0:0] {StStop, StRun} state_e;

  state_e     state_q, state_d;
  logic [7:0] sec_q, sec_d;
  logic [7:0] min_q, min_d;
  logic       carry_q, carry_d;
  logic       load_err_q, load_err_d;

  logic       count_en;
  logic       load_ok;
  logic [8:0] sec_inc;
  logic [8:0] min_inc;

  // True when a two-digit BCD value lies in 00..59.
  function automatic logic bcd_ok(input logic [7:0] v);
    return (v[3:0] <= 4'd9) && (v[7:4] <= 4'd5);
  endfunction

  // Mod-60 BCD increment; returns {wrap, next}. Corrupt values recover to 00 without wrap.
  function automatic logic [8:0] bcd_inc(input logic [7:0] v);
    logic [8:0] r;
    if (!bcd_ok(v)) begin
      r = {1'b0, 8'h00};
    end else if (v[3:0] != 4'd9) begin
      r = {1'b0, v[7:4], v[3:0] + 4'd1};
    end else if (v[7:4] != 4'd5) begin
      r = {1'b0, v[7:4] + 4'd1, 4'd0};
    end else begin
      r = {1'b1, 8'h00};
    end
    return r;
  endfunction

  // State register; reset state selectable by parameter.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q <= RUN_AT_RESET ? StRun : StStop;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: START_STOP toggles regardless of CLEAR/LOAD.
  always_comb begin
    state_d = state_q;
    if (START_STOP) begin
      state_d = (state_q == StRun) ? StStop : StRun;
    end
  end

  // FSM output decode.
  always_comb begin
    RUNNING = (state_q == StRun);
  end

  // Counting uses the pre-toggle state; CLEAR and LOAD both suppress the count.
  always_comb begin
    count_en = (state_q == StRun) && ENABLE && !CLEAR && !LOAD;
    load_ok  = bcd_ok(LOAD_SEC) && bcd_ok(LOAD_MIN) && (MIN_EN || (LOAD_MIN == 8'h00));
    sec_inc  = bcd_inc(sec_q);
    min_inc  = bcd_inc(min_q);
  end

  // Digit / carry / error next-state with CLEAR > LOAD > count priority.
  always_comb begin
    sec_d      = sec_q;
    min_d      = min_q;
    carry_d    = 1'b0;
    load_err_d = 1'b0;
    if (CLEAR) begin
      sec_d = 8'h00;
      min_d = 8'h00;
    end else if (LOAD) begin
      if (load_ok) begin
        sec_d = LOAD_SEC;
        min_d = MIN_EN ? LOAD_MIN : 8'h00;
      end else begin
        load_err_d = 1'b1;
      end
    end else if (count_en) begin
      sec_d = sec_inc[7:0];
      if (!MIN_EN) begin
        min_d   = 8'h00;
        carry_d = sec_inc[8];
      end else if (sec_inc[8]) begin
        min_d   = min_inc[7:0];
        carry_d = min_inc[8];
      end else if (!bcd_ok(min_q)) begin
        min_d = 8'h00;
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      sec_q      <= 8'h00;
      min_q      <= 8'h00;
      carry_q    <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      sec_q      <= sec_d;
      min_q      <= min_d;
      carry_q    <= carry_d;
      load_err_q <= load_err_d;
    end
  end

  // Registered outputs.
  always_comb begin
    SEC      = sec_q;
    MIN      = min_q;
    CARRY    = carry_q;
    LOAD_ERR = load_err_q;
  end

endmodule

// File: tb/tb_cnt60_bcd_timer.sv
// Bench for cnt60_bcd_timer: one instance with the minutes stage, one without,
// driven in lock-step and compared against a seconds-total reference model.
module tb_cnt60_bcd_timer;

  logic       CLK = 1'b0;
  logic       RESET, ENABLE, START_STOP, CLEAR, LOAD;
  logic [7:0] LOAD_MIN, LOAD_SEC;
  logic [7:0] sec0, min0, sec1, min1;
  logic       run0, car0, err0, run1, car1, err1;

  int total = 0;
  int bad   = 0;

  // Reference model: elapsed seconds as a plain integer per instance.
  int m_tot[2];
  bit m_run[2];
  bit m_car[2];
  bit m_err[2];

  always #5 CLK = ~CLK;

  cnt60_bcd_timer #(.MIN_EN(1'b1), .RUN_AT_RESET(1'b0)) dut0 (
    .CLK(CLK), .RESET(RESET), .ENABLE(ENABLE), .START_STOP(START_STOP), .CLEAR(CLEAR),
    .LOAD(LOAD), .LOAD_MIN(LOAD_MIN), .LOAD_SEC(LOAD_SEC), .SEC(sec0), .MIN(min0),
    .RUNNING(run0), .CARRY(car0), .LOAD_ERR(err0)
  );

  cnt60_bcd_timer #(.MIN_EN(1'b0), .RUN_AT_RESET(1'b0)) dut1 (
    .CLK(CLK), .RESET(RESET), .ENABLE(ENABLE), .START_STOP(START_STOP), .CLEAR(CLEAR),
    .LOAD(LOAD), .LOAD_MIN(LOAD_MIN), .LOAD_SEC(LOAD_SEC), .SEC(sec1), .MIN(min1),
    .RUNNING(run1), .CARRY(car1), .LOAD_ERR(err1)
  );

  function automatic int bcd2int(input logic [7:0] v);
    return int'(v[7:4]) * 10 + int'(v[3:0]);
  endfunction

  function automatic logic [7:0] int2bcd(input int n);
    logic [7:0] r;
    r[7:4] = 4'(n / 10);
    r[3:0] = 4'(n % 10);
    return r;
  endfunction

  function automatic bit legal_bcd(input logic [7:0] v);
    return (int'(v[7:4]) < 6) && (int'(v[3:0]) < 10);
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_update(input int k, input bit rst_n, input bit en, input bit ss,
                              input bit clr, input bit ld, input logic [7:0] lm,
                              input logic [7:0] ls);
    bit men;
    bit cnt;
    int modulus;
    men = (k == 0);
    if (!rst_n) begin
      m_tot[k] = 0;
      m_run[k] = 1'b0;
      m_car[k] = 1'b0;
      m_err[k] = 1'b0;
    end else begin
      cnt      = m_run[k] && en && !clr && !ld;
      m_car[k] = 1'b0;
      m_err[k] = 1'b0;
      if (clr) begin
        m_tot[k] = 0;
      end else if (ld) begin
        if (legal_bcd(lm) && legal_bcd(ls) && (men || lm == 8'h00)) begin
          m_tot[k] = bcd2int(lm) * 60 + bcd2int(ls);
        end else begin
          m_err[k] = 1'b1;
        end
      end else if (cnt) begin
        modulus  = men ? 3600 : 60;
        m_tot[k] = (m_tot[k] + 1) % modulus;
        m_car[k] = (m_tot[k] == 0);
      end
      if (ss) m_run[k] = !m_run[k];
    end
  endtask

  task automatic check_all();
    chk("d0.sec", sec0, int2bcd(m_tot[0] % 60));
    chk("d0.min", min0, int2bcd(m_tot[0] / 60));
    chk("d0.running", {7'd0, run0}, {7'd0, m_run[0]});
    chk("d0.carry", {7'd0, car0}, {7'd0, m_car[0]});
    chk("d0.load_err", {7'd0, err0}, {7'd0, m_err[0]});
    chk("d1.sec", sec1, int2bcd(m_tot[1] % 60));
    chk("d1.min", min1, int2bcd(m_tot[1] / 60));
    chk("d1.running", {7'd0, run1}, {7'd0, m_run[1]});
    chk("d1.carry", {7'd0, car1}, {7'd0, m_car[1]});
    chk("d1.load_err", {7'd0, err1}, {7'd0, m_err[1]});
  endtask

  // One clock of stimulus: drive, clock, advance model, sample 1 time unit after the edge.
  task automatic step(input bit rst_n, input bit en, input bit ss, input bit clr, input bit ld,
                      input logic [7:0] lm, input logic [7:0] ls);
    RESET      = rst_n;
    ENABLE     = en;
    START_STOP = ss;
    CLEAR      = clr;
    LOAD       = ld;
    LOAD_MIN   = lm;
    LOAD_SEC   = ls;
    @(posedge CLK);
    model_update(0, rst_n, en, ss, clr, ld, lm, ls);
    model_update(1, rst_n, en, ss, clr, ld, lm, ls);
    #1;
    check_all();
  endtask

  task automatic idle();
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
  endtask

  task automatic en_pulse();
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
  endtask

  task automatic load(input logic [7:0] lm, input logic [7:0] ls);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, lm, ls);
  endtask

  initial begin
    bit         r_rst, r_en, r_ss, r_clr, r_ld;
    logic [7:0] r_lm, r_ls;

    // Reset state
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00);

    // Start, then 61 pulses -> 01:01 (00:01 without minutes)
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    repeat (61) begin
      en_pulse();
      idle();
    end

    // Full wrap 59:58 -> 59:59 -> 00:00 with single-cycle carry
    load(8'h59, 8'h58);
    en_pulse();
    idle();
    en_pulse();
    idle();
    idle();

    // Seconds-only wrap on the instance without minutes
    load(8'h00, 8'h59);
    en_pulse();
    idle();

    // Rejected loads keep digits and pulse LOAD_ERR
    load(8'h00, 8'h5A);
    idle();
    load(8'h00, 8'h60);
    idle();
    load(8'h60, 8'h00);
    idle();
    load(8'h0A, 8'h00);
    idle();

    // LOAD with ENABLE in RUN: preset wins, no count
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h12, 8'h32);
    idle();

    // START_STOP+ENABLE in RUN counts and stops; in STOP only starts
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    idle();
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    idle();

    // Reach 12:34 then CLEAR with ENABLE
    en_pulse();
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00);
    idle();

    // Reset mid-count at 07:07
    load(8'h07, 8'h06);
    en_pulse();
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    idle();

    // STOP ignores ENABLE; RUN counts back-to-back ENABLE cycles
    load(8'h03, 8'h08);
    repeat (10) begin
      en_pulse();
      idle();
    end
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    repeat (3) en_pulse();
    idle();

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      r_rst = ($urandom_range(0, 299) != 0);
      r_en  = ($urandom_range(0, 2) != 0);
      r_ss  = ($urandom_range(0, 23) == 0);
      r_clr = ($urandom_range(0, 63) == 0);
      r_ld  = ($urandom_range(0, 19) == 0);
      case ($urandom_range(0, 3))
        0: begin
          r_lm = int2bcd(int'($urandom_range(0, 59)));
          r_ls = int2bcd(int'($urandom_range(0, 59)));
        end
        1: begin
          r_lm = 8'h59;
          r_ls = int2bcd(int'($urandom_range(50, 59)));
        end
        2: begin
          r_lm = 8'h00;
          r_ls = int2bcd(int'($urandom_range(55, 59)));
        end
        default: begin
          r_lm = 8'($urandom);
          r_ls = 8'($urandom);
        end
      endcase
      step(r_rst, r_en, r_ss, r_clr, r_ld, r_lm, r_ls);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
